half_adder: RTL and testbench

- Parameterizable bank of WIDTH independent 1-bit half adders.
- Per lane: sum = a XOR b, carry = a AND b.
- Optional output register stage, an in/out valid flag, and a saturating carry-event counter for debug.
- Leaf arithmetic cell used in adder trees and in FPGA bring-up demos; the default configuration is a pure combinational 1-bit half adder.

---
 rtl/half_adder_if.sv | 49 ++++
 rtl/half_adder.sv | 82 ++++++++
 tb/tb_half_adder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/half_adder_if.sv
// Operand/result bundle for the half_adder lane bank.
// Latency: none (wiring only); the attached half_adder sets result timing.
// Backpressure: none; in_valid qualifies a sample and there is no ready path.
//
// Signals:
//   a_in, b_in     operands, one bit per lane          (master -> slave)
//   in_valid       qualifies a_in/b_in                 (master -> slave)
//   cnt_clr        synchronous clear of carry_events   (master -> slave)
//   sum_out        per-lane a XOR b                    (slave -> master)
//   carry_out      per-lane a AND b                    (slave -> master)
//   out_valid      qualifies sum_out/carry_out         (slave -> master)
//   carry_events   saturating count of carry samples   (slave -> master)
interface half_adder_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             in_valid;
    logic             cnt_clr;
    logic [WIDTH-1:0] sum_out;
    logic [WIDTH-1:0] carry_out;
    logic             out_valid;
    logic [CNT_W-1:0] carry_events;

    // Stimulus / consumer side.
    modport master (
        output a_in,
        output b_in,
        output in_valid,
        output cnt_clr,
        input  sum_out,
        input  carry_out,
        input  out_valid,
        input  carry_events
    );

    // Half-adder side.
    modport slave (
        input  a_in,
        input  b_in,
        input  in_valid,
        input  cnt_clr,
        output sum_out,
        output carry_out,
        output out_valid,
        output carry_events
    );
endinterface

// File: rtl/half_adder.sv
// Bank of WIDTH independent 1-bit half adders with a saturating carry-event counter.
// Latency: 0 cycles when REG_OUT=0, exactly 1 cycle when REG_OUT=1; one result per cycle.
// Backpressure: none; samples with in_valid=0 are ignored (registered results hold).
//
// Ports:
//   clk    rising-edge clock for the result registers and the counter
//   rst_n  asynchronous active-low reset; clears registered results and counter
//   ha     half_adder_if slave: a_in/b_in/in_valid/cnt_clr in,
//          sum_out/carry_out/out_valid/carry_events out
module half_adder #(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 0,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    half_adder_if.slave ha
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Lane arithmetic: no carry crosses lanes, so every bit is independent.
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] carry_c;

    assign sum_c   = ha.a_in ^ ha.b_in;
    assign carry_c = ha.a_in & ha.b_in;

    // A sample counts as a carry event when accepted and any lane carries.
    logic carry_hit;
    assign carry_hit = ha.in_valid & (|carry_c);

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [WIDTH-1:0] sum_q;
            logic [WIDTH-1:0] carry_q;
            logic             vld_q;

            // Results load only on accepted samples; out_valid tracks
            // whether the most recent edge carried a fresh result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q   <= '0;
                    carry_q <= '0;
                    vld_q   <= 1'b0;
                end else begin
                    vld_q <= ha.in_valid;
                    if (ha.in_valid) begin
                        sum_q   <= sum_c;
                        carry_q <= carry_c;
                    end
                end
            end

            assign ha.sum_out   = sum_q;
            assign ha.carry_out = carry_q;
            assign ha.out_valid = vld_q;
        end else begin : g_comb
            // Pure combinational path; reset and clock do not touch it.
            assign ha.sum_out   = sum_c;
            assign ha.carry_out = carry_c;
            assign ha.out_valid = ha.in_valid;
        end
    endgenerate

    // Debug counter: clear wins over increment, and it sticks at all-ones.
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (ha.cnt_clr) begin
            cnt_q <= '0;
        end else if (carry_hit && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign ha.carry_events = cnt_q;

endmodule

// File: tb/tb_half_adder.sv
module tb_half_adder;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_err;

    // u0: default combinational 1-lane cell.
    half_adder_if #(.WIDTH(1), .CNT_W(16)) i0 ();
    half_adder #(.WIDTH(1), .REG_OUT(0), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .ha(i0.slave));

    // u1: 4 lanes, registered, 2-bit counter for saturation.
    half_adder_if #(.WIDTH(4), .CNT_W(2)) i1 ();
    half_adder #(.WIDTH(4), .REG_OUT(1), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .ha(i1.slave));

    // u2: 1 lane, registered, wide counter.
    half_adder_if #(.WIDTH(1), .CNT_W(16)) i2 ();
    half_adder #(.WIDTH(1), .REG_OUT(1), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .ha(i2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model for u1 (lane sums computed as integer a+b).
    int m_sum;
    int m_carry;
    int m_vld;
    int m_cnt;

    task automatic model_step(input int a, input int b, input int v, input int clr, input int cmax);
        int s;
        int c;
        int any;
        s = 0;
        c = 0;
        any = 0;
        for (int l = 0; l < 4; l++) begin
            int t;
            t = ((a >> l) & 1) + ((b >> l) & 1);
            s += (t % 2) << l;
            c += (t / 2) << l;
            if (t == 2) any = 1;
        end
        if (v != 0) begin
            m_sum   = s;
            m_carry = c;
        end
        m_vld = v;
        if (clr != 0) m_cnt = 0;
        else if (v != 0 && any != 0 && m_cnt < cmax) m_cnt = m_cnt + 1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_sum = 0; m_carry = 0; m_vld = 0; m_cnt = 0;

        rst_n = 1'b0;
        i0.a_in = '0; i0.b_in = '0; i0.in_valid = 1'b0; i0.cnt_clr = 1'b0;
        i1.a_in = '0; i1.b_in = '0; i1.in_valid = 1'b0; i1.cnt_clr = 1'b0;
        i2.a_in = '0; i2.b_in = '0; i2.in_valid = 1'b0; i2.cnt_clr = 1'b0;
        repeat (2) tick();

        // Reset state of registered instances.
        chk("rst_u1_sum",  32'(i1.sum_out), 0);
        chk("rst_u1_car",  32'(i1.carry_out), 0);
        chk("rst_u1_vld",  32'(i1.out_valid), 0);
        chk("rst_u1_cnt",  32'(i1.carry_events), 0);
        chk("rst_u2_vld",  32'(i2.out_valid), 0);
        chk("rst_u0_cnt",  32'(i0.carry_events), 0);

        // Combinational sweep on u0, done while in reset (reset must not matter).
        for (int k = 0; k < 4; k++) begin
            int a;
            int b;
            a = k >> 1;
            b = k & 1;
            i0.a_in = 1'(a);
            i0.b_in = 1'(b);
            i0.in_valid = 1'(k & 1);
            #10;
            chk("comb_sum", 32'(i0.sum_out), 32'((a + b) % 2));
            chk("comb_car", 32'(i0.carry_out), 32'((a + b) / 2));
            chk("comb_vld", 32'(i0.out_valid), 32'(k & 1));
        end
        i0.in_valid = 1'b0;

        rst_n = 1'b1;
        tick();

        // u0 counter: three carry samples, then an unqualified one.
        i0.a_in = 1'b1; i0.b_in = 1'b1; i0.in_valid = 1'b1;
        repeat (3) tick();
        chk("u0_cnt3", 32'(i0.carry_events), 3);
        i0.in_valid = 1'b0;
        tick();
        chk("u0_cnt_hold", 32'(i0.carry_events), 3);

        // u2: one-cycle latency, then hold with in_valid low.
        i2.a_in = 1'b1; i2.b_in = 1'b1; i2.in_valid = 1'b1;
        #1;
        chk("u2_pre_vld", 32'(i2.out_valid), 0);
        tick();
        chk("u2_sum", 32'(i2.sum_out), 0);
        chk("u2_car", 32'(i2.carry_out), 1);
        chk("u2_vld", 32'(i2.out_valid), 1);
        i2.a_in = 1'b0; i2.b_in = 1'b1; i2.in_valid = 1'b0;
        tick();
        chk("u2_hold_sum", 32'(i2.sum_out), 0);
        chk("u2_hold_car", 32'(i2.carry_out), 1);
        chk("u2_hold_vld", 32'(i2.out_valid), 0);
        chk("u2_cnt1", 32'(i2.carry_events), 1);

        // u1: multi-lane vector.
        i1.a_in = 4'b1100; i1.b_in = 4'b1010; i1.in_valid = 1'b1;
        model_step(12, 10, 1, 0, 3);
        tick();
        chk("u1_vec_sum", 32'(i1.sum_out), 32'(m_sum));
        chk("u1_vec_car", 32'(i1.carry_out), 32'(m_carry));
        chk("u1_vec_cnt", 32'(i1.carry_events), 32'(m_cnt));

        // u1: clear, then saturation sequence 1,2,3,3,3.
        i1.in_valid = 1'b0; i1.cnt_clr = 1'b1;
        model_step(12, 10, 0, 1, 3);
        tick();
        chk("u1_clr", 32'(i1.carry_events), 0);
        i1.cnt_clr = 1'b0;
        i1.a_in = 4'hF; i1.b_in = 4'hF; i1.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            model_step(15, 15, 1, 0, 3);
            tick();
            chk("u1_sat", 32'(i1.carry_events), 32'((k < 3) ? k + 1 : 3));
        end
        // Clear beats a concurrent carry sample.
        i1.cnt_clr = 1'b1;
        model_step(15, 15, 1, 1, 3);
        tick();
        chk("u1_clr_pri", 32'(i1.carry_events), 0);
        i1.cnt_clr = 1'b0;
        // Qualification: carry without valid, valid without carry.
        i1.in_valid = 1'b0;
        model_step(15, 15, 0, 0, 3);
        tick();
        chk("u1_qual_nv", 32'(i1.carry_events), 0);
        i1.a_in = 4'hF; i1.b_in = 4'h0; i1.in_valid = 1'b1;
        model_step(15, 0, 1, 0, 3);
        tick();
        chk("u1_qual_nc", 32'(i1.carry_events), 0);
        chk("u1_qual_sum", 32'(i1.sum_out), 32'hF);

        // u1: randomized traffic against the model.
        for (int k = 0; k < 60; k++) begin
            int a;
            int b;
            int v;
            int c;
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            v = int'($urandom_range(0, 1));
            c = ($urandom_range(0, 7) == 0) ? 1 : 0;
            i1.a_in = 4'(a); i1.b_in = 4'(b); i1.in_valid = 1'(v); i1.cnt_clr = 1'(c);
            model_step(a, b, v, c, 3);
            tick();
            chk("rnd_sum", 32'(i1.sum_out), 32'(m_sum));
            chk("rnd_car", 32'(i1.carry_out), 32'(m_carry));
            chk("rnd_vld", 32'(i1.out_valid), 32'(m_vld));
            chk("rnd_cnt", 32'(i1.carry_events), 32'(m_cnt));
        end
        i1.in_valid = 1'b0; i1.cnt_clr = 1'b0;

        // u2: bring carry_events to 5 with out_valid high, then async reset.
        i2.a_in = 1'b1; i2.b_in = 1'b1; i2.in_valid = 1'b1;
        repeat (4) tick();
        chk("u2_cnt5", 32'(i2.carry_events), 5);
        chk("u2_vld_pre", 32'(i2.out_valid), 1);
        chk("u2_car_pre", 32'(i2.carry_out), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_car", 32'(i2.carry_out), 0);
        chk("arst_sum", 32'(i2.sum_out), 0);
        chk("arst_vld", 32'(i2.out_valid), 0);
        chk("arst_cnt", 32'(i2.carry_events), 0);
        chk("arst_u0_car", 32'(i0.carry_out), 1);

        // Release between edges; first capture is the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        i2.a_in = 1'b1; i2.b_in = 1'b0; i2.in_valid = 1'b1;
        #1;
        chk("rel_pre_vld", 32'(i2.out_valid), 0);
        tick();
        chk("rel_sum", 32'(i2.sum_out), 1);
        chk("rel_car", 32'(i2.carry_out), 0);
        chk("rel_vld", 32'(i2.out_valid), 1);
        chk("rel_cnt", 32'(i2.carry_events), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
